// File: rtl/lcd_defs.sv
// Shared LTM panel definitions: active geometry, pattern codes, colour-bar table,
// and the pipeline stage records used by lcd_pattern_gen.
package lcd_defs;

  localparam int unsigned H_ACT = 800;
  localparam int unsigned V_ACT = 480;
  localparam int unsigned CW    = 11;

  typedef enum logic [1:0] {
    BARS   = 2'd0,
    GRID   = 2'd1,
    GRAD   = 2'd2,
    SQUARE = 2'd3
  } pat_e;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] SQ_BG = 24'h000040;

  // Index 0 is the leftmost bar.
  localparam logic [0:7][23:0] BAR_RGB = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  typedef struct packed {
    logic       den;
    logic       hd;
    logic       vd;
    logic       in_rng;
    logic [2:0] bar;
    logic       grid;
    logic       sq;
    logic [7:0] grad_r;
    logic [7:0] grad_g;
  } s1_t;

  typedef struct packed {
    logic        den;
    logic        hd;
    logic        vd;
    logic [23:0] rgb;
  } s2_t;

  localparam s1_t S1_RST = '{den: 1'b0, hd: 1'b1, vd: 1'b1, in_rng: 1'b0, bar: 3'd0,
                             grid: 1'b0, sq: 1'b0, grad_r: 8'd0, grad_g: 8'd0};
  localparam s2_t S2_RST = '{den: 1'b0, hd: 1'b1, vd: 1'b1, rgb: 24'd0};

endpackage

// File: rtl/lcd_pattern_gen_if.sv
// Raster in (from lcd_sync) and pixel/sync out (to the panel) for lcd_pattern_gen.
interface lcd_pattern_gen_if;
  logic        DEN;
  logic        HD;
  logic        VD;
  logic [9:0]  fila;
  logic [10:0] columna;
  logic [7:0]  R;
  logic [7:0]  G;
  logic [7:0]  B;
  logic        HD_O;
  logic        VD_O;
  logic        DEN_O;
  logic [1:0]  PAT;

  modport master (
    output DEN, HD, VD, fila, columna,
    input  R, G, B, HD_O, VD_O, DEN_O, PAT
  );

  modport slave (
    input  DEN, HD, VD, fila, columna,
    output R, G, B, HD_O, VD_O, DEN_O, PAT
  );
endinterface

// File: rtl/btn_edge.sv
// Push-button conditioning: 2-flop synchroniser followed by a rising-edge detector
// producing a single-cycle PULSE.
module btn_edge (
  input  logic CLK,
  input  logic RST,
  input  logic BTN,
  output logic PULSE
);

  // [0],[1] synchronise; [2] holds the previous synchronised level.
  logic [2:0] sync_d, sync_q;

  always_comb sync_d = {sync_q[1:0], BTN};

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign PULSE = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source behind lcd_sync: 2-stage pipeline, button-selected pattern
// switched at frame boundaries. Optional auto-rotation: LCD_PATTERN_AUTO_CYCLE_EN.
module lcd_pattern_gen
  import lcd_defs::*;
#(
  parameter int unsigned SQ      = 64,
  parameter int unsigned SQ_STEP = 4
`ifdef LCD_PATTERN_AUTO_CYCLE_EN
  , parameter int unsigned AUTO_N = 120
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  lcd_pattern_gen_if.slave bus
);

  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] H_LAST   = CW'(H_ACT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_ACT - 1);
  localparam logic [CW-1:0] GRAD_SAT = CW'(1020);
  localparam int unsigned   BAR_W    = H_ACT / 8;
  localparam logic [CW-1:0] SQ_Y0    = CW'(V_ACT / 2 - SQ / 2);
  localparam logic [CW-1:0] SQ_Y1    = CW'(V_ACT / 2 + SQ / 2 - 1);
  localparam logic [CW-1:0] SQ_SPAN  = CW'(SQ - 1);
  localparam logic [CW-1:0] SQ_ADV   = CW'(SQ_STEP);
  localparam logic [CW-1:0] SQ_REACH = CW'(SQ_STEP + SQ);

  logic [CW-1:0] col, fil;
  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  pat_e          pat_d, pat_q;
  logic          pend_d, pend_q;
  logic [CW-1:0] sqx_d, sqx_q;
  logic          pulse, auto_set, fb;

  btn_edge u_btn (.CLK(CLK), .RST(RST), .BTN(BTN), .PULSE(pulse));

  assign col = bus.columna;
  assign fil = {1'b0, bus.fila};

  // Stage 1: register the raster inputs together with every region decision.
  always_comb begin
    s1_d        = S1_RST;
    s1_d.den    = bus.DEN;
    s1_d.hd     = bus.HD;
    s1_d.vd     = bus.VD;
    s1_d.in_rng = col < H_ACT_C;
    s1_d.bar    = 3'd0;
    for (int k = 1; k < 8; k++)
      if (col >= CW'(k * BAR_W)) s1_d.bar = 3'(k);
    s1_d.grid   = (col[4:0] == 5'd0) || (fil[4:0] == 5'd0) || (col == H_LAST) || (fil == V_LAST);
    s1_d.grad_r = (col >= GRAD_SAT) ? 8'hFF : col[9:2];
    s1_d.grad_g = fil[8:1];
    s1_d.sq     = (col >= sqx_q) && (col <= sqx_q + SQ_SPAN) && (fil >= SQ_Y0) && (fil <= SQ_Y1);
  end

  // Stage 2: colour; blanking and out-of-range pixels are black.
  always_comb begin
    s2_d     = S2_RST;
    s2_d.den = s1_q.den;
    s2_d.hd  = s1_q.hd;
    s2_d.vd  = s1_q.vd;
    if (s1_q.den && s1_q.in_rng) begin
      case (pat_q)
        BARS:   s2_d.rgb = BAR_RGB[s1_q.bar];
        GRID:   s2_d.rgb = s1_q.grid ? WHITE : 24'h000000;
        GRAD:   s2_d.rgb = {s1_q.grad_r, s1_q.grad_g, 8'h40};
        SQUARE: s2_d.rgb = s1_q.sq ? WHITE : SQ_BG;
      endcase
    end
  end

  // End of vsync: stage-1 VD high while stage-2 VD still low.
  assign fb = s1_q.vd & ~s2_q.vd;

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
  localparam int unsigned FC_W = (AUTO_N > 1) ? $clog2(AUTO_N) : 1;
  logic [FC_W-1:0] fcnt_d, fcnt_q;

  always_comb begin
    fcnt_d   = fcnt_q;
    auto_set = 1'b0;
    if (fb) begin
      if (fcnt_q == FC_W'(AUTO_N - 1)) begin
        fcnt_d   = '0;
        auto_set = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end
`else
  assign auto_set = 1'b0;
`endif

  // A request raised in the fb cycle itself is kept for the following boundary.
  always_comb begin
    pat_d  = pat_q;
    pend_d = pend_q;
    sqx_d  = sqx_q;
    if (fb) begin
      sqx_d = (sqx_q + SQ_REACH > H_ACT_C) ? '0 : sqx_q + SQ_ADV;
      if (pend_q) begin
        pat_d  = pat_e'(pat_q + 2'd1);
        pend_d = 1'b0;
      end
    end
    if (pulse || auto_set) pend_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q   <= S1_RST;
      s2_q   <= S2_RST;
      pat_q  <= BARS;
      pend_q <= 1'b0;
      sqx_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      pat_q  <= pat_d;
      pend_q <= pend_d;
      sqx_q  <= sqx_d;
    end
  end

  assign bus.R     = s2_q.rgb[23:16];
  assign bus.G     = s2_q.rgb[15:8];
  assign bus.B     = s2_q.rgb[7:0];
  assign bus.HD_O  = s2_q.hd;
  assign bus.VD_O  = s2_q.vd;
  assign bus.DEN_O = s2_q.den;
  assign bus.PAT   = pat_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed bench for lcd_pattern_gen using short synthetic frames (vsync + sparse pixels).
module tb_lcd_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  always #10 clk = ~clk;

  lcd_pattern_gen_if bus();

`ifdef LCD_PATTERN_AUTO_CYCLE_EN
  lcd_pattern_gen #(.AUTO_N(3)) dut (.CLK(clk), .RST(rst), .BTN(btn), .bus(bus));
`else
  lcd_pattern_gen dut (.CLK(clk), .RST(rst), .BTN(btn), .bus(bus));
`endif

  int errors = 0;
  int checks = 0;
  int sqx_exp = 0;
  logic obs_vd_pre, obs_vd_low, obs_hd_low;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.DEN = 1'b0; bus.HD = 1'b1; bus.VD = 1'b1;
  endtask

  // One pixel in, result sampled two cycles later.
  task automatic px(input bit den, input int f, input int c,
                    output logic [23:0] rgb, output logic deno);
    bus.DEN = den; bus.fila = 10'(f); bus.columna = 11'(c);
    tick();
    bus.DEN = 1'b0;
    tick();
    rgb  = {bus.R, bus.G, bus.B};
    deno = bus.DEN_O;
  endtask

  // Short vsync pulse; optionally raises BTN so its pulse lands on the fb cycle.
  task automatic frame_sync(input bit btn_fb);
    bus.DEN = 1'b0; bus.HD = 1'b0; bus.VD = 1'b0;
    tick();
    obs_vd_pre = bus.VD_O;
    if (btn_fb) btn = 1'b1;
    tick();
    obs_vd_low = bus.VD_O;
    obs_hd_low = bus.HD_O;
    bus.HD = 1'b1; bus.VD = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    sqx_exp = (sqx_exp == 736) ? 0 : sqx_exp + 4;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [23:0] rgb;
    rst = 1'b1; btn = 1'b0;
    bus.DEN = 1'b1; bus.HD = 1'b0; bus.VD = 1'b1; bus.fila = 10'd10; bus.columna = 11'd0;
    repeat (5) tick();
    rgb = {bus.R, bus.G, bus.B};
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    checks++; if (bus.HD_O !== 1'b1) begin errors++; $display("FAIL reset_hd_o got %b want 1", bus.HD_O); end
    checks++; if (bus.VD_O !== 1'b1) begin errors++; $display("FAIL reset_vd_o got %b want 1", bus.VD_O); end
    checks++; if (bus.DEN_O !== 1'b0) begin errors++; $display("FAIL reset_den_o got %b want 0", bus.DEN_O); end
    checks++; if (bus.PAT !== 2'd0) begin errors++; $display("FAIL reset_pat got %0d want 0", bus.PAT); end
    rst = 1'b0;
    idle();
    repeat (3) tick();
    bus.DEN = 1'b1; bus.fila = 10'd10; bus.columna = 11'd0;
    tick();
    checks++; if (bus.DEN_O !== 1'b0) begin errors++; $display("FAIL den_lat1 got %b want 0", bus.DEN_O); end
    tick();
    rgb = {bus.R, bus.G, bus.B};
    checks++; if (bus.DEN_O !== 1'b1) begin errors++; $display("FAIL den_lat2 got %b want 1", bus.DEN_O); end
    checks++; if (rgb !== 24'hFFFFFF) begin errors++; $display("FAIL first_px got %h want ffffff", rgb); end
    idle();
    repeat (2) tick();
    frame_sync(1'b0);
    checks++; if (obs_vd_pre !== 1'b1) begin errors++; $display("FAIL vd_lat1 got %b want 1", obs_vd_pre); end
    checks++; if (obs_vd_low !== 1'b0) begin errors++; $display("FAIL vd_lat2 got %b want 0", obs_vd_low); end
    checks++; if (obs_hd_low !== 1'b0) begin errors++; $display("FAIL hd_lat2 got %b want 0", obs_hd_low); end
    checks++; if (bus.PAT !== 2'd0) begin errors++; $display("FAIL idle_fb_pat got %0d want 0", bus.PAT); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] rgb;
    bus.DEN = 1'b1; bus.fila = 10'd10; bus.columna = 11'd0;
    tick();
    rst = 1'b1;
    tick();
    rgb = {bus.R, bus.G, bus.B};
    checks++; if (rgb !== 24'h0 || bus.DEN_O !== 1'b0)
      begin errors++; $display("FAIL midrst_clear got %h/%b want 000000/0", rgb, bus.DEN_O); end
    rst = 1'b0;
    tick();
    rgb = {bus.R, bus.G, bus.B};
    checks++; if (rgb !== 24'h0 || bus.DEN_O !== 1'b0)
      begin errors++; $display("FAIL midrst_hold got %h/%b want 000000/0", rgb, bus.DEN_O); end
    tick();
    rgb = {bus.R, bus.G, bus.B};
    checks++; if (rgb !== 24'hFFFFFF || bus.DEN_O !== 1'b1)
      begin errors++; $display("FAIL midrst_resume got %h/%b want ffffff/1", rgb, bus.DEN_O); end
    idle();
    repeat (2) tick();
    sqx_exp = 0;
  endtask

  task automatic test_bars();
    int          cols[10] = '{0, 99, 100, 250, 350, 450, 550, 650, 799, 800};
    logic [23:0] exps[10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    logic [23:0] rgb;
    logic        d;
    for (int i = 0; i < 10; i++) begin
      px(1'b1, 10, cols[i], rgb, d);
      checks++; if (rgb !== exps[i] || d !== 1'b1)
        begin errors++; $display("FAIL bars col=%0d got %h/%b want %h/1", cols[i], rgb, d, exps[i]); end
    end
    px(1'b0, 10, 0, rgb, d);
    checks++; if (rgb !== 24'h0 || d !== 1'b0)
      begin errors++; $display("FAIL blank got %h/%b want 000000/0", rgb, d); end
  endtask

  task automatic test_btn();
    int          gf[7] = '{10, 10, 32, 10, 479, 478, 10};
    int          gc[7] = '{0, 33, 33, 799, 5, 5, 800};
    logic [23:0] ge[7] = '{24'hFFFFFF, 24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
    int          df[4] = '{100, 479, 0, 3};
    int          dc[4] = '{400, 799, 0, 7};
    logic [23:0] de[4] = '{24'h643240, 24'hC7EF40, 24'h000040, 24'h010140};
    logic [23:0] rgb;
    logic        d;
    px(1'b1, 10, 0, rgb, d);
    press();
    press();
    repeat (4) tick();
    checks++; if (bus.PAT !== 2'd0) begin errors++; $display("FAIL btn_midframe got %0d want 0", bus.PAT); end
    frame_sync(1'b0);
    checks++; if (bus.PAT !== 2'd1) begin errors++; $display("FAIL btn_fb1 got %0d want 1", bus.PAT); end
    frame_sync(1'b0);
    checks++; if (bus.PAT !== 2'd1) begin errors++; $display("FAIL btn_single_step got %0d want 1", bus.PAT); end
    for (int i = 0; i < 7; i++) begin
      px(1'b1, gf[i], gc[i], rgb, d);
      checks++; if (rgb !== ge[i])
        begin errors++; $display("FAIL grid f=%0d c=%0d got %h want %h", gf[i], gc[i], rgb, ge[i]); end
    end
    press();
    checks++; if (bus.PAT !== 2'd1) begin errors++; $display("FAIL btn2_midframe got %0d want 1", bus.PAT); end
    frame_sync(1'b0);
    checks++; if (bus.PAT !== 2'd2) begin errors++; $display("FAIL btn_fb2 got %0d want 2", bus.PAT); end
    for (int i = 0; i < 4; i++) begin
      px(1'b1, df[i], dc[i], rgb, d);
      checks++; if (rgb !== de[i])
        begin errors++; $display("FAIL grad f=%0d c=%0d got %h want %h", df[i], dc[i], rgb, de[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] seq[4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      press();
      frame_sync(1'b0);
      checks++; if (bus.PAT !== seq[i])
        begin errors++; $display("FAIL wrap step=%0d got %0d want %0d", i, bus.PAT, seq[i]); end
    end
    frame_sync(1'b1);
    checks++; if (bus.PAT !== 2'd2) begin errors++; $display("FAIL btn_on_fb got %0d want 2", bus.PAT); end
    frame_sync(1'b0);
    checks++; if (bus.PAT !== 2'd3) begin errors++; $display("FAIL btn_on_fb_next got %0d want 3", bus.PAT); end
  endtask

  task automatic test_square();
    logic [23:0] rgb, bg;
    logic        d;
    int          fails = 0;
    bit          saw_wrap = 1'b0;
    for (int fr = 0; fr < 186; fr++) begin
      frame_sync(1'b0);
      if (sqx_exp == 0 && fr > 0) saw_wrap = 1'b1;
      bg = (sqx_exp + 64 < 800) ? 24'h000040 : 24'h000000;
      px(1'b1, 240, sqx_exp + 63, rgb, d);
      checks++; if (rgb !== 24'hFFFFFF)
        begin errors++; fails++; if (fails < 10) $display("FAIL sq_right_in sqx=%0d got %h want ffffff", sqx_exp, rgb); end
      px(1'b1, 240, sqx_exp + 64, rgb, d);
      checks++; if (rgb !== bg)
        begin errors++; fails++; if (fails < 10) $display("FAIL sq_right_out sqx=%0d got %h want %h", sqx_exp, rgb, bg); end
      px(1'b1, 208, sqx_exp, rgb, d);
      checks++; if (rgb !== 24'hFFFFFF)
        begin errors++; fails++; if (fails < 10) $display("FAIL sq_top_in sqx=%0d got %h want ffffff", sqx_exp, rgb); end
      px(1'b1, 207, sqx_exp, rgb, d);
      checks++; if (rgb !== 24'h000040)
        begin errors++; fails++; if (fails < 10) $display("FAIL sq_top_out sqx=%0d got %h want 000040", sqx_exp, rgb); end
      px(1'b1, 272, sqx_exp + 10, rgb, d);
      checks++; if (rgb !== 24'h000040)
        begin errors++; fails++; if (fails < 10) $display("FAIL sq_bot_out sqx=%0d got %h want 000040", sqx_exp, rgb); end
    end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL sq_wrap got 0 want 1"); end
    checks++; if (bus.PAT !== 2'd3) begin errors++; $display("FAIL sq_pat got %0d want 3", bus.PAT); end
  endtask

  task automatic test_no_auto();
    for (int k = 1; k <= 10; k++) begin
      frame_sync(1'b0);
      checks++; if (bus.PAT !== 2'd3)
        begin errors++; $display("FAIL no_auto frame=%0d got %0d want 3", k, bus.PAT); end
    end
  endtask

  task automatic test_auto();
    logic [1:0] e;
    for (int k = 1; k <= 10; k++) begin
      frame_sync(1'b0);
      e = 2'(((k - 1) / 3) % 4);
      checks++; if (bus.PAT !== e)
        begin errors++; $display("FAIL auto frame=%0d got %0d want %0d", k, bus.PAT, e); end
    end
  endtask

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid();
`ifdef LCD_PATTERN_AUTO_CYCLE_EN
    test_auto();
`else
    test_bars();
    test_btn();
    test_wrap();
    test_square();
    test_no_auto();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
